// File: rtl/segment_table_ctrl_if.sv
// Segment table bus: CPU store port, clear-busy status and display read port.
interface segment_table_ctrl_if;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned VIDX_W = 7;

    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              busy;
    logic              vga_req;
    logic [VIDX_W-1:0] vga_idx;
    logic              vga_ack;
    logic [DATA_W-1:0] vga_x;
    logic [DATA_W-1:0] vga_y;

    // Requester side: CPU and display controller
    modport master (
        output cpu_wren, cpu_addr, cpu_data, vga_req, vga_idx,
        input  busy, vga_ack, vga_x, vga_y
    );

    // Table controller side
    modport slave (
        input  cpu_wren, cpu_addr, cpu_data, vga_req, vga_idx,
        output busy, vga_ack, vga_x, vga_y
    );
endinterface

// File: rtl/segment_table_ctrl.sv
// Snake segment coordinate tables (X and Y) written by CPU stores and read by
// the display. Optional hardware clear sequencer enabled by SEG_HW_CLEAR_EN:
// a store to CLEAR_ADDR sweeps both tables to the empty marker, yielding the
// write port to CPU stores. Without the macro, CLEAR_ADDR stores are ignored.
module segment_table_ctrl #(
    parameter int unsigned DEPTH      = 100,
    parameter int unsigned X_BASE     = 300,
    parameter int unsigned Y_BASE     = 400,
    parameter int unsigned CLEAR_ADDR = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    segment_table_ctrl_if.slave  bus
);
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] EMPTY = '1;

    typedef logic [DATA_W-1:0] word_t;

    word_t x_q [DEPTH];
    word_t x_d [DEPTH];
    word_t y_q [DEPTH];
    word_t y_d [DEPTH];

    logic             clr_store_c;
    logic             x_hit_c;
    logic             y_hit_c;
    logic [IDX_W-1:0] x_off_c;
    logic [IDX_W-1:0] y_off_c;
    logic             clr_wr_c;
    logic [IDX_W-1:0] clr_idx_c;

    logic             vga_ack_q, vga_ack_d;
    word_t            vga_x_q, vga_x_d;
    word_t            vga_y_q, vga_y_d;

    // CPU store address decode; the clear register is never a table store
    always_comb begin
        clr_store_c = bus.cpu_wren && (bus.cpu_addr == ADDR_W'(CLEAR_ADDR));
        x_hit_c     = bus.cpu_wren && !clr_store_c
                      && (bus.cpu_addr >= ADDR_W'(X_BASE))
                      && (bus.cpu_addr <= ADDR_W'(X_BASE + DEPTH - 1));
        y_hit_c     = bus.cpu_wren && !clr_store_c
                      && (bus.cpu_addr >= ADDR_W'(Y_BASE))
                      && (bus.cpu_addr <= ADDR_W'(Y_BASE + DEPTH - 1));
        x_off_c     = IDX_W'(bus.cpu_addr - ADDR_W'(X_BASE));
        y_off_c     = IDX_W'(bus.cpu_addr - ADDR_W'(Y_BASE));
    end

`ifdef SEG_HW_CLEAR_EN
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             busy_q, busy_d;

    // Clear sequencer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // Clear sequencer next state: sweep indices, stall on CPU table stores
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_wr_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_store_c) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                if (!(x_hit_c || y_hit_c)) begin
                    clr_wr_c = 1'b1;
                    if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_d   = IDLE;
                        clr_idx_d = '0;
                    end else begin
                        clr_idx_d = clr_idx_q + IDX_W'(1);
                    end
                end
                if (clr_store_c) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    assign clr_idx_c = clr_idx_q;
    assign bus.busy  = busy_q;
`else
    assign clr_wr_c  = 1'b0;
    assign clr_idx_c = '0;
    assign bus.busy  = 1'b0;
`endif

    // Table next contents: CPU store wins, otherwise the clear sweep
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_wr_c) begin
            x_d[clr_idx_c] = EMPTY;
            y_d[clr_idx_c] = EMPTY;
        end
        if (x_hit_c) begin
            x_d[x_off_c] = bus.cpu_data;
        end
        if (y_hit_c) begin
            y_d[y_off_c] = bus.cpu_data;
        end
    end

    // Table storage, every entry empty out of reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                x_q[i] <= EMPTY;
                y_q[i] <= EMPTY;
            end
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Display read: pre-write contents, empty marker beyond the table
    always_comb begin
        vga_ack_d = bus.vga_req;
        vga_x_d   = vga_x_q;
        vga_y_d   = vga_y_q;
        if (bus.vga_req) begin
            if (32'(bus.vga_idx) < DEPTH) begin
                vga_x_d = x_q[IDX_W'(bus.vga_idx)];
                vga_y_d = y_q[IDX_W'(bus.vga_idx)];
            end else begin
                vga_x_d = EMPTY;
                vga_y_d = EMPTY;
            end
        end
    end

    // Display read output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_ack_q <= 1'b0;
            vga_x_q   <= EMPTY;
            vga_y_q   <= EMPTY;
        end else begin
            vga_ack_q <= vga_ack_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
        end
    end

    assign bus.vga_ack = vga_ack_q;
    assign bus.vga_x   = vga_x_q;
    assign bus.vga_y   = vga_y_q;
endmodule

// File: tb/tb_segment_table_ctrl.sv
// Scoreboard bench for segment_table_ctrl: reads push expected data, a
// negedge monitor pops and compares on every vga_ack.
module tb_segment_table_ctrl;
    localparam logic [31:0] E = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [15:0] tag;
        logic [31:0] cyc;
        logic [31:0] x;
        logic [31:0] y;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   busy_cnt = 0;
    int   cyc      = 0;
    int   rd_seq   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    segment_table_ctrl_if bus ();

    segment_table_ctrl #(
        .DEPTH(100), .X_BASE(300), .Y_BASE(400), .CLEAR_ADDR(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare each acknowledged read with the oldest expectation
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.vga_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("read%0d_cycle", mon_e.tag), 32'(cyc), mon_e.cyc);
                check($sformatf("read%0d_x", mon_e.tag), bus.vga_x, mon_e.x);
                check($sformatf("read%0d_y", mon_e.tag), bus.vga_y, mon_e.y);
            end
        end
        if (reset === 1'b0 && bus.busy === 1'b1) busy_cnt++;
    end

    // One clock of stimulus; inputs change 1ns after the active edge
    task automatic drive(input logic wr, input logic [11:0] a, input logic [31:0] d,
                         input logic rd, input logic [6:0] i,
                         input logic [31:0] ex, input logic [31:0] ey);
        bus.cpu_wren = wr;
        bus.cpu_addr = a;
        bus.cpu_data = d;
        bus.vga_req  = rd;
        bus.vga_idx  = i;
        if (rd) begin
            exp_q.push_back('{tag: 16'(rd_seq), cyc: 32'(cyc + 1), x: ex, y: ey});
            rd_seq++;
        end
        @(posedge clock);
        #1;
        bus.cpu_wren = 1'b0;
        bus.vga_req  = 1'b0;
    endtask

    task automatic store(input logic [11:0] a, input logic [31:0] d);
        drive(1'b1, a, d, 1'b0, 7'd0, E, E);
    endtask

    task automatic read(input logic [6:0] i, input logic [31:0] ex, input logic [31:0] ey);
        drive(1'b0, 12'd0, 32'd0, 1'b1, i, ex, ey);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 12'd0, 32'd0, 1'b0, 7'd0, E, E);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            idle(1);
            n++;
        end
        check("clear_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000ns expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.cpu_wren = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_data = '0;
        bus.vga_req  = 1'b0;
        bus.vga_idx  = '0;
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ack", 32'(bus.vga_ack), 32'd0);
        check("rst_x", bus.vga_x, E);
        check("rst_y", bus.vga_y, E);
        #10 reset = 1'b0;
        @(posedge clock);
        #1;

        // Empty tables after reset, both ends
        read(7'd0, E, E);
        read(7'd99, E, E);

        // Stores, with reads landing in the store cycles (read-old)
        drive(1'b1, 12'd300, 32'd12, 1'b1, 7'd0, E, E);
        drive(1'b1, 12'd400, 32'd7, 1'b1, 7'd0, 32'd12, E);
        read(7'd0, 32'd12, 32'd7);

        // Out-of-range reads and stores just outside the tables
        read(7'd120, E, E);
        read(7'd127, E, E);
        store(12'd299, 32'd1);
        store(12'd500, 32'd2);
        read(7'd0, 32'd12, 32'd7);
        read(7'd99, E, E);
        store(12'd399, 32'hA);
        store(12'd499, 32'hB);
        read(7'd99, 32'hA, 32'hB);

`ifdef SEG_HW_CLEAR_EN
        // Full clear of filled entries
        for (int i = 0; i < 4; i++) begin
            store(12'(300 + i), 32'(i + 1));
            store(12'(400 + i), 32'(i + 16));
        end
        read(7'd3, 32'd4, 32'd19);
        busy_cnt = 0;
        store(12'd5, 32'd0);
        check("busy_on", 32'(bus.busy), 32'd1);
        wait_idle();
        check("busy_cycles_plain", 32'(busy_cnt), 32'd100);
        for (int i = 0; i < 4; i++) read(7'(i), E, E);
        read(7'd99, E, E);

        // CPU store at clr_idx 10 stalls the sweep one cycle
        store(12'd350, 32'h50);
        busy_cnt = 0;
        store(12'd5, 32'd0);
        idle(10);
        store(12'd310, 32'd55);
        read(7'd10, 32'd55, E);
        wait_idle();
        check("busy_cycles_stall10", 32'(busy_cnt), 32'd101);
        read(7'd10, E, E);
        read(7'd50, E, E);

        // CPU store ahead of the sweep at clr_idx 20 is cleared later
        busy_cnt = 0;
        store(12'd5, 32'd0);
        idle(20);
        store(12'd350, 32'd99);
        read(7'd50, 32'd99, E);
        wait_idle();
        check("busy_cycles_stall20", 32'(busy_cnt), 32'd101);
        read(7'd50, E, E);
        read(7'd20, E, E);

        // Clear store while clearing restarts the sweep
        busy_cnt = 0;
        store(12'd5, 32'd0);
        idle(30);
        store(12'd5, 32'd0);
        wait_idle();
        check("busy_cycles_restart", 32'(busy_cnt), 32'd131);
`else
        // Clear register ignored; software clears by individual stores
        busy_cnt = 0;
        store(12'd5, 32'd0);
        check("busy_off", 32'(bus.busy), 32'd0);
        idle(3);
        check("busy_never", 32'(busy_cnt), 32'd0);
        read(7'd0, 32'd12, 32'd7);
        store(12'd300, E);
        store(12'd400, E);
        read(7'd0, E, E);
`endif

        // Reset in the middle of operation wipes written entries
        for (int i = 60; i < 100; i++) begin
            store(12'(300 + i), 32'(i));
            store(12'(400 + i), 32'(i + 1000));
        end
        read(7'd60, 32'd60, 32'd1060);
        read(7'd99, 32'd99, 32'd1099);
        idle(2);
`ifdef SEG_HW_CLEAR_EN
        store(12'd5, 32'd0);
        idle(40);
        check("busy_before_rst", 32'(bus.busy), 32'd1);
`endif
        reset = 1'b1;
        #2;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_ack", 32'(bus.vga_ack), 32'd0);
        check("midrst_x", bus.vga_x, E);
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 60; i < 100; i++) read(7'(i), E, E);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        store(12'd300, 32'd9);
        read(7'd0, 32'd9, E);

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/segment_table_ctrl.md
SEGMENT_TABLE_CTRL -- requirements
Module: segment_table_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 100, meaning number of snake segments per coordinate table.
REQ-002 SHALL have parameter X_BASE, default 300, meaning first dmem word address of the X table.
REQ-003 SHALL have parameter Y_BASE, default 400, meaning first dmem word address of the Y table.
REQ-004 SHALL have parameter CLEAR_ADDR, default 5, meaning dmem word address whose store triggers a table clear.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cpu_wren  input  1  processor store strobe.
REQ-008 SHALL have port cpu_addr  input  12  processor dmem word address.
REQ-009 SHALL have port cpu_data  input  32  processor store data.
REQ-010 SHALL have port busy  output  1  clear sequence in progress.
REQ-011 SHALL have port vga_req  input  1  display read request.
REQ-012 SHALL have port vga_idx  input  7  segment index to read.
REQ-013 SHALL have port vga_ack  output  1  read data valid, one-cycle pulse.
REQ-014 SHALL have port vga_x  output  32  X coordinate of requested segment.
REQ-015 SHALL have port vga_y  output  32  Y coordinate of requested segment.

Function
REQ-016 SHALL hold two DEPTH x 32 tables, X and Y, each with exactly one write port; 32'hFFFFFFFF marks an empty segment.
REQ-017 SHALL write cpu_data into X[cpu_addr-X_BASE] at the posedge where cpu_wren=1 and X_BASE <= cpu_addr <= X_BASE+DEPTH-1; Y table likewise with Y_BASE.
REQ-018 SHALL ignore stores to all other addresses except CLEAR_ADDR; CPU stores are never stalled or dropped.
REQ-019 SHALL implement FSM states IDLE and CLEAR; IDLE -> CLEAR on a store to CLEAR_ADDR; CLEAR -> IDLE the cycle after the entry at index DEPTH-1 has been cleared.
REQ-020 SHALL in CLEAR write 32'hFFFFFFFF to X[clr_idx] and Y[clr_idx] each cycle, starting at clr_idx=0 and incrementing by 1.
REQ-021 SHALL give the CPU priority on a table's write port: a CPU store to either table in CLEAR holds clr_idx for that cycle and clears neither table at that index.
REQ-022 SHALL restart clr_idx at 0 on a store to CLEAR_ADDR received while in CLEAR.
REQ-023 SHALL drive busy=1 exactly while in CLEAR; an uninterrupted clear lasts DEPTH cycles.
REQ-024 SHALL sample vga_req/vga_idx at posedge and, the following cycle, pulse vga_ack=1 with vga_x/vga_y equal to the table contents before that posedge's writes (read-old on collision).
REQ-025 SHALL return 32'hFFFFFFFF on both vga_x and vga_y for vga_idx >= DEPTH, still acknowledging.
REQ-026 SHALL service one read per cycle in any state; vga_x/vga_y hold their last value while vga_ack=0.

Reset
REQ-027 SHALL on reset asynchronously set every table entry to 32'hFFFFFFFF, state to IDLE, clr_idx to 0, busy to 0, vga_ack to 0, vga_x and vga_y to 32'hFFFFFFFF.
REQ-028 SHALL abandon an in-progress clear on reset and resume normal operation from the first posedge after reset deasserts.

Configuration
REQ-029 SHALL compile the hardware clear sequencer only when macro SEG_HW_CLEAR_EN is defined.
REQ-030 SHALL, without SEG_HW_CLEAR_EN, treat stores to CLEAR_ADDR as ignored, tie busy to 0, and require software to clear entries by individual stores.

Verification
REQ-031 SHALL cover: after reset, read idx 0 and 99 -> vga_ack one cycle later, vga_x = vga_y = 32'hFFFFFFFF.
REQ-032 SHALL cover: store 12 to addr 300 and 7 to addr 400, then read idx 0 -> vga_x=12, vga_y=7; read issued in the store cycle -> old value 32'hFFFFFFFF.
REQ-033 SHALL cover (SEG_HW_CLEAR_EN): fill entries 0..3, store to addr 5 -> busy high 100 cycles, then all reads return 32'hFFFFFFFF.
REQ-034 SHALL cover: during clear at clr_idx=10, store 55 to addr 310 -> busy lasts 101 cycles, idx 10 X reads 32'hFFFFFFFF (cleared next cycle); store to addr 350 at clr_idx=20 -> X[50] later reads 32'hFFFFFFFF.
REQ-035 SHALL cover: read idx 120 -> ack with 32'hFFFFFFFF; store to addr 299 and 500 -> no table change.
REQ-036 SHALL cover: reset asserted mid-clear at clr_idx=40 -> busy=0 immediately, previously written entries 60..99 read 32'hFFFFFFFF.
